// File: rtl/uni_arbiter_if.sv
// Uni request/response bundle shared by the requester ports and the bridge port.
// master drives the request fields; slave returns the completion pulse and read data.
interface uni_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic                  valid;
    logic                  reqtyp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  cachable;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, reqtyp, addr, size, cachable, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, reqtyp, addr, size, cachable, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/uni_arbiter.sv
// Two-requester arbiter (IFU = port 0, LSU = port 1) in front of the single uni-to-AXI bridge.
// A grant locks the owner onto the bridge until the bridge's one-cycle ready pulse.
module uni_arbiter #(
    parameter int UNI_ADDR_WIDTH = 32,
    parameter int UNI_DATA_WIDTH = 128,
    parameter int ARB_MODE       = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uni_arbiter_if.slave     p0,
    uni_arbiter_if.slave     p1,
    uni_arbiter_if.master    out,
    output logic             o_busy,
    output logic             o_owner
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                    state_q;
    state_e                    state_d;
    logic                      owner_q;
    logic                      owner_d;
    logic                      last_grant_q;
    logic                      last_grant_d;
    logic                      winner_s;
    logic                      busy_s;
    logic                      owner_valid_s;
    logic                      mux_reqtyp_s;
    logic [UNI_ADDR_WIDTH-1:0] mux_addr_s;
    logic [1:0]                mux_size_s;
    logic                      mux_cachable_s;
    logic [UNI_DATA_WIDTH-1:0] mux_wdata_s;

    // Winner of an IDLE-cycle request; a round-robin tie goes to the port not granted last.
    always_comb begin
        winner_s = 1'b0;
        if (p0.valid && p1.valid) begin
            if (ARB_MODE != 0) begin
                winner_s = 1'b1;
            end else begin
                winner_s = ~last_grant_q;
            end
        end else if (p1.valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state logic: grant from IDLE, release on the bridge completion pulse.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (p0.valid || p1.valid) begin
                    state_d = ST_BUSY;
                    owner_d = winner_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (out.ready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and fairness registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Request mux: the owner's fields go to the bridge unregistered.
    always_comb begin
        owner_valid_s  = 1'b0;
        mux_reqtyp_s   = 1'b0;
        mux_addr_s     = {UNI_ADDR_WIDTH{1'b0}};
        mux_size_s     = 2'd0;
        mux_cachable_s = 1'b0;
        mux_wdata_s    = {UNI_DATA_WIDTH{1'b0}};
        if (owner_q) begin
            owner_valid_s  = p1.valid;
            mux_reqtyp_s   = p1.reqtyp;
            mux_addr_s     = p1.addr;
            mux_size_s     = p1.size;
            mux_cachable_s = p1.cachable;
            mux_wdata_s    = p1.wdata;
        end else begin
            owner_valid_s  = p0.valid;
            mux_reqtyp_s   = p0.reqtyp;
            mux_addr_s     = p0.addr;
            mux_size_s     = p0.size;
            mux_cachable_s = p0.cachable;
            mux_wdata_s    = p0.wdata;
        end
    end

    assign busy_s = (state_q == ST_BUSY);

    // The ready mask keeps the bridge from restarting on the owner's still-held valid.
    assign out.valid    = busy_s & owner_valid_s & ~out.ready;
    assign out.reqtyp   = mux_reqtyp_s;
    assign out.addr     = mux_addr_s;
    assign out.size     = mux_size_s;
    assign out.cachable = mux_cachable_s;
    assign out.wdata    = mux_wdata_s;

    assign p0.ready = busy_s & ~owner_q & out.ready;
    assign p1.ready = busy_s &  owner_q & out.ready;
    assign p0.rdata = out.rdata;
    assign p1.rdata = out.rdata;

    assign o_busy  = busy_s;
    assign o_owner = owner_q;

endmodule

// File: tb/tb_uni_arbiter.sv
// Directed bench: a round-robin arbiter (dut_a) and a fixed-priority one (dut_b) see the same stimulus.
module tb_uni_arbiter;

    logic         clk;
    logic         rst_n;
    logic         p0_valid, p0_reqtyp, p0_cachable;
    logic [31:0]  p0_addr;
    logic [1:0]   p0_size;
    logic [127:0] p0_wdata;
    logic         p1_valid, p1_reqtyp, p1_cachable;
    logic [31:0]  p1_addr;
    logic [1:0]   p1_size;
    logic [127:0] p1_wdata;
    logic         out_ready;
    logic [127:0] out_rdata;
    logic         busy_a, owner_a, busy_b, owner_b;
    int           vectors;
    int           errors;

    uni_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) p0_a ();
    uni_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) p1_a ();
    uni_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) out_a ();
    uni_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) p0_b ();
    uni_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) p1_b ();
    uni_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) out_b ();

    assign p0_a.valid = p0_valid;   assign p0_b.valid = p0_valid;
    assign p0_a.reqtyp = p0_reqtyp; assign p0_b.reqtyp = p0_reqtyp;
    assign p0_a.addr = p0_addr;     assign p0_b.addr = p0_addr;
    assign p0_a.size = p0_size;     assign p0_b.size = p0_size;
    assign p0_a.cachable = p0_cachable; assign p0_b.cachable = p0_cachable;
    assign p0_a.wdata = p0_wdata;   assign p0_b.wdata = p0_wdata;
    assign p1_a.valid = p1_valid;   assign p1_b.valid = p1_valid;
    assign p1_a.reqtyp = p1_reqtyp; assign p1_b.reqtyp = p1_reqtyp;
    assign p1_a.addr = p1_addr;     assign p1_b.addr = p1_addr;
    assign p1_a.size = p1_size;     assign p1_b.size = p1_size;
    assign p1_a.cachable = p1_cachable; assign p1_b.cachable = p1_cachable;
    assign p1_a.wdata = p1_wdata;   assign p1_b.wdata = p1_wdata;
    assign out_a.ready = out_ready; assign out_b.ready = out_ready;
    assign out_a.rdata = out_rdata; assign out_b.rdata = out_rdata;

    uni_arbiter #(.UNI_ADDR_WIDTH(32), .UNI_DATA_WIDTH(128), .ARB_MODE(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .p0(p0_a), .p1(p1_a), .out(out_a),
        .o_busy(busy_a), .o_owner(owner_a)
    );

    uni_arbiter #(.UNI_ADDR_WIDTH(32), .UNI_DATA_WIDTH(128), .ARB_MODE(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .p0(p0_b), .p1(p1_b), .out(out_b),
        .o_busy(busy_b), .o_owner(owner_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        p0_valid = 1'b0; p0_reqtyp = 1'b0; p0_cachable = 1'b0; p0_addr = 32'h0; p0_size = 2'd0; p0_wdata = 128'h0;
        p1_valid = 1'b0; p1_reqtyp = 1'b0; p1_cachable = 1'b0; p1_addr = 32'h0; p1_size = 2'd0; p1_wdata = 128'h0;
        out_ready = 1'b0; out_rdata = 128'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        p0_valid = 1'b1;
        tick();
        #1;
        vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        vectors++; if (owner_a !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b want 0", owner_a); end
        vectors++; if (out_a.valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_a.valid); end
        out_ready = 1'b1;
        #1;
        vectors++; if ({p0_a.ready, p1_a.ready, p0_b.ready, p1_b.ready} !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", {p0_a.ready, p1_a.ready, p0_b.ready, p1_b.ready}); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_idle_stay: got %b want 0", busy_a); end
    endtask

    task automatic test_single_read();
        do_reset();
        p0_valid = 1'b1; p0_reqtyp = 1'b0; p0_addr = 32'h8000_0000; p0_size = 2'd2; p0_cachable = 1'b1;
        #1;
        vectors++; if (out_a.valid !== 1'b0) begin errors++; $display("FAIL sr_latency: got %b want 0", out_a.valid); end
        tick();
        #1;
        vectors++; if (out_a.valid !== 1'b1) begin errors++; $display("FAIL sr_out_valid: got %b want 1", out_a.valid); end
        vectors++; if (out_a.addr !== 32'h8000_0000) begin errors++; $display("FAIL sr_out_addr: got %h want 80000000", out_a.addr); end
        vectors++; if (out_a.cachable !== 1'b1) begin errors++; $display("FAIL sr_cachable: got %b want 1", out_a.cachable); end
        vectors++; if ({busy_a, owner_a} !== 2'b10) begin errors++; $display("FAIL sr_busy_owner: got %b want 10", {busy_a, owner_a}); end
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1; out_rdata = 128'h11223344_55667788_99AABBCC_DDEEF0FF;
        #1;
        vectors++; if ({p0_a.ready, p1_a.ready} !== 2'b10) begin errors++; $display("FAIL sr_ready: got %b want 10", {p0_a.ready, p1_a.ready}); end
        vectors++; if (p0_a.rdata !== 128'h11223344_55667788_99AABBCC_DDEEF0FF) begin errors++; $display("FAIL sr_rdata: got %h", p0_a.rdata); end
        vectors++; if (out_a.valid !== 1'b0) begin errors++; $display("FAIL sr_valid_mask: got %b want 0", out_a.valid); end
        tick();
        p0_valid = 1'b0; out_ready = 1'b0;
        #1;
        vectors++; if ({busy_a, p0_a.ready} !== 2'b00) begin errors++; $display("FAIL sr_idle_after: got %b want 00", {busy_a, p0_a.ready}); end
    endtask

    task automatic test_round_robin();
        logic exp_a [3];
        exp_a[0] = 1'b0; exp_a[1] = 1'b1; exp_a[2] = 1'b0;
        do_reset();
        p0_valid = 1'b1; p0_addr = 32'h0000_0100;
        p1_valid = 1'b1; p1_addr = 32'h0000_0200;
        for (int g = 0; g < 3; g++) begin
            tick();
            #1;
            vectors++; if (owner_a !== exp_a[g]) begin errors++; $display("FAIL rr_owner_%0d: got %b want %b", g, owner_a, exp_a[g]); end
            vectors++; if (owner_b !== 1'b1) begin errors++; $display("FAIL fp_owner_%0d: got %b want 1", g, owner_b); end
            vectors++; if (out_a.addr !== (exp_a[g] ? 32'h0000_0200 : 32'h0000_0100)) begin errors++; $display("FAIL rr_addr_%0d: got %h", g, out_a.addr); end
            out_ready = 1'b1;
            #1;
            vectors++; if ({p1_a.ready, p0_a.ready} !== (exp_a[g] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ready_%0d: got %b", g, {p1_a.ready, p0_a.ready}); end
            vectors++; if ({p1_b.ready, p0_b.ready} !== 2'b10) begin errors++; $display("FAIL fp_ready_%0d: got %b want 10", g, {p1_b.ready, p0_b.ready}); end
            tick();
            out_ready = 1'b0;
            #1;
            vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rr_idle_%0d: got %b want 0", g, busy_a); end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        p0_valid = 1'b1; p0_addr = 32'h0000_0100;
        p1_valid = 1'b1; p1_addr = 32'h0000_0200;
        tick();
        #1;
        vectors++; if (owner_b !== 1'b1) begin errors++; $display("FAIL fp_first: got %b want 1", owner_b); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; p1_valid = 1'b0;
        tick();
        #1;
        vectors++; if ({busy_b, owner_b} !== 2'b10) begin errors++; $display("FAIL fp_ifu_after: got %b want 10", {busy_b, owner_b}); end
        vectors++; if (out_b.addr !== 32'h0000_0100) begin errors++; $display("FAIL fp_ifu_addr: got %h want 00000100", out_b.addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        p0_valid = 1'b1; p0_reqtyp = 1'b0; p0_addr = 32'h8000_0040; p0_size = 2'd3; p0_cachable = 1'b1;
        tick();
        p1_valid = 1'b1; p1_reqtyp = 1'b1; p1_addr = 32'h1000_0003; p1_size = 2'd0; p1_cachable = 1'b0; p1_wdata = 128'hAB;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if ({out_a.addr, out_a.reqtyp, out_a.size} !== {32'h8000_0040, 1'b0, 2'd3}) begin errors++; $display("FAIL b2b_hold_%0d: got %h %b %0d", i, out_a.addr, out_a.reqtyp, out_a.size); end
            vectors++; if (p1_a.ready !== 1'b0) begin errors++; $display("FAIL b2b_no_ready_%0d: got %b want 0", i, p1_a.ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++; if ({p0_a.ready, p1_a.ready} !== 2'b10) begin errors++; $display("FAIL b2b_ifu_done: got %b want 10", {p0_a.ready, p1_a.ready}); end
        tick();
        out_ready = 1'b0; p0_valid = 1'b0;
        #1;
        vectors++; if ({busy_a, out_a.valid} !== 2'b00) begin errors++; $display("FAIL b2b_gap: got %b want 00", {busy_a, out_a.valid}); end
        tick();
        #1;
        vectors++; if ({out_a.valid, owner_a, out_a.reqtyp} !== 3'b111) begin errors++; $display("FAIL b2b_lsu_grant: got %b want 111", {out_a.valid, owner_a, out_a.reqtyp}); end
        vectors++; if ({out_a.addr, out_a.size} !== {32'h1000_0003, 2'd0}) begin errors++; $display("FAIL b2b_lsu_addr: got %h %0d", out_a.addr, out_a.size); end
        vectors++; if (out_a.wdata !== 128'hAB) begin errors++; $display("FAIL b2b_lsu_wdata: got %h want ab", out_a.wdata); end
        out_ready = 1'b1;
        #1;
        vectors++; if ({p0_a.ready, p1_a.ready} !== 2'b01) begin errors++; $display("FAIL b2b_lsu_done: got %b want 01", {p0_a.ready, p1_a.ready}); end
        tick();
        out_ready = 1'b0; p1_valid = 1'b0;
    endtask

    task automatic test_violation();
        do_reset();
        p0_valid = 1'b1; p0_addr = 32'h0000_0400;
        tick();
        p0_valid = 1'b0;
        #1;
        vectors++; if ({busy_a, out_a.valid} !== 2'b10) begin errors++; $display("FAIL vio_drop: got %b want 10", {busy_a, out_a.valid}); end
        tick();
        #1;
        vectors++; if (busy_a !== 1'b1) begin errors++; $display("FAIL vio_stay_busy: got %b want 1", busy_a); end
        out_ready = 1'b1;
        tick();
        #1;
        vectors++; if ({busy_a, p0_a.ready, p1_a.ready} !== 3'b000) begin errors++; $display("FAIL idle_ready_ignored: got %b want 000", {busy_a, p0_a.ready, p1_a.ready}); end
        tick();
        #1;
        vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_ready_stay: got %b want 0", busy_a); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        p0_valid = 1'b1; p0_addr = 32'h8000_0080;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++; if ({out_a.valid, p0_a.ready, p1_a.ready, busy_a, owner_a} !== 5'b00000) begin errors++; $display("FAIL arst_outputs: got %b want 00000", {out_a.valid, p0_a.ready, p1_a.ready, busy_a, owner_a}); end
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        #1;
        vectors++; if ({busy_a, out_a.valid, owner_a} !== 3'b110) begin errors++; $display("FAIL arst_regrant: got %b want 110", {busy_a, out_a.valid, owner_a}); end
        vectors++; if (out_a.addr !== 32'h8000_0080) begin errors++; $display("FAIL arst_addr: got %h want 80000080", out_a.addr); end
        p0_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_back_to_back();
        test_violation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
